skinny_sbox_layer_ctrl: RTL

Sequencer that applies the first-order HPC1 pipelined Skinny S-box to a full masked 64-bit Skinny state, one nibble per cycle. It serialises 16 two-share nibbles into the single S-box instance, feeds the S-box fresh-randomness input from a PRNG handshake, and tracks each in-flight nibble through the 5-stage pipeline. It also reassembles the masked state for the round datapath. It sits between the round-function controller and the S-box netlist.

---
 rtl/skinny_sbox_pkg.sv | 7 +
 rtl/sbox_share_collector.sv | 42 ++++
 rtl/skinny_sbox_layer_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/skinny_sbox_pkg.sv
// skinny_sbox_pkg: shared constants and FSM state type for the masked Skinny S-box layer sequencer
package skinny_sbox_pkg;
  localparam int SBOX_LATENCY = 5;
  localparam int NUM_NIBBLES = 16;
  localparam int RND_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, WAIT_RND, FEED, DRAIN, DONE} ctrl_state_t;
endpackage

// File: rtl/sbox_share_collector.sv
// sbox_share_collector: valid tag pipe tracking nibbles in flight through the S-box, plus per-share result shift registers
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr_tag         : flush the tag pipe (new pass or underrun)
//   clr_out         : zero both result registers
//   push            : tag bit entering the pipe this cycle (1 = real nibble issued)
//   y_s0 / y_s1     : S-box result shares
//   out_s0 / out_s1 : reassembled result shares, nibble i at [4i+3:4i]
module sbox_share_collector
  import skinny_sbox_pkg::*;
#(
  parameter int LAT = SBOX_LATENCY,
  parameter int W = 4 * NUM_NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_tag,
  input  logic         clr_out,
  input  logic         push,
  input  logic [3:0]   y_s0,
  input  logic [3:0]   y_s1,
  output logic [W-1:0] out_s0,
  output logic [W-1:0] out_s1
);
  logic [LAT-1:0] tag;
  // each share has its own chain; results enter at the MSB so the first nibble ends up at the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
      out_s0 <= '0;
      out_s1 <= '0;
    end else begin
      tag <= clr_tag ? '0 : {tag[LAT-2:0], push};
      if (clr_out) begin
        out_s0 <= '0;
        out_s1 <= '0;
      end else if (tag[LAT-1]) begin
        out_s0 <= {y_s0, out_s0[W-1:4]};
        out_s1 <= {y_s1, out_s1[W-1:4]};
      end
    end
  end
endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// skinny_sbox_layer_ctrl: serialises a two-share 64-bit Skinny state through one pipelined HPC1 S-box, nibble per cycle
//   start, state_in_s0/s1          : pass request and input shares (sampled in IDLE)
//   busy, done, err                : pass in progress, result-valid pulse, sticky randomness underrun
//   state_out_s0/s1                : result shares, stable from done until next accepted start
//   sbox_x_s0/s1, sbox_y_s0/s1     : nibble shares to / results from the external S-box
//   sbox_fresh                     : S-box fresh randomness
//   rnd_req, rnd_valid, rnd_data   : PRNG handshake
// Build option SBOX_CTRL_ZEROIZE_EN: consumed input nibbles are zeroed, sbox_x is 0 outside FEED,
// and result registers are cleared on accepted start.
module skinny_sbox_layer_ctrl
  import skinny_sbox_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [63:0]          state_in_s0,
  input  logic [63:0]          state_in_s1,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [63:0]          state_out_s0,
  output logic [63:0]          state_out_s1,
  output logic [3:0]           sbox_x_s0,
  output logic [3:0]           sbox_x_s1,
  input  logic [3:0]           sbox_y_s0,
  input  logic [3:0]           sbox_y_s1,
  output logic [RND_WIDTH-1:0] sbox_fresh,
  output logic                 rnd_req,
  input  logic                 rnd_valid,
  input  logic [RND_WIDTH-1:0] rnd_data
);
  localparam int W = 4 * NUM_NIBBLES;
  localparam int CW = $clog2(NUM_NIBBLES);
`ifdef SBOX_CTRL_ZEROIZE_EN
  localparam logic ZEROIZE = 1'b1;
`else
  localparam logic ZEROIZE = 1'b0;
`endif
  ctrl_state_t state;
  logic [CW-1:0] cnt;
  logic [W-1:0] sr0, sr1;
  logic [3:0] hold0, hold1;
  logic [RND_WIDTH-1:0] fresh_q;
  logic accept, feed, drain, underrun;
  assign accept = state == IDLE && start;
  assign feed = state == FEED;
  assign drain = state == DRAIN;
  // every FEED/DRAIN cycle clocks the S-box and needs a fresh word
  assign underrun = (feed || drain) && !rnd_valid;
  assign sbox_fresh = (feed || drain) ? rnd_data : fresh_q;
  assign sbox_x_s0 = feed ? sr0[3:0] : (ZEROIZE ? 4'h0 : hold0);
  assign sbox_x_s1 = feed ? sr1[3:0] : (ZEROIZE ? 4'h0 : hold1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rnd_req <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= WAIT_RND;
          busy <= 1'b1;
          rnd_req <= 1'b1;
          err <= 1'b0;
        end
        WAIT_RND: if (rnd_valid) begin
          state <= FEED;
          cnt <= '0;
        end
        FEED: if (!rnd_valid) begin
          state <= IDLE;
          busy <= 1'b0;
          rnd_req <= 1'b0;
          err <= 1'b1;
        end else if (cnt == CW'(NUM_NIBBLES - 1)) begin
          state <= DRAIN;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        DRAIN: if (!rnd_valid) begin
          state <= IDLE;
          busy <= 1'b0;
          rnd_req <= 1'b0;
          err <= 1'b1;
        end else if (cnt == CW'(SBOX_LATENCY - 1)) begin
          state <= DONE;
          done <= 1'b1;
          rnd_req <= 1'b0;
        end else cnt <= cnt + 1'b1;
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // input shares rotate (or drain to zero) so the next nibble is always at the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr0 <= '0;
      sr1 <= '0;
      hold0 <= '0;
      hold1 <= '0;
      fresh_q <= '0;
    end else begin
      if (accept) begin
        sr0 <= state_in_s0;
        sr1 <= state_in_s1;
      end else if (feed) begin
        sr0 <= {ZEROIZE ? 4'h0 : sr0[3:0], sr0[W-1:4]};
        sr1 <= {ZEROIZE ? 4'h0 : sr1[3:0], sr1[W-1:4]};
        hold0 <= sr0[3:0];
        hold1 <= sr1[3:0];
      end
      if ((feed || drain) && rnd_valid) fresh_q <= rnd_data;
    end
  end
  sbox_share_collector #(.LAT(SBOX_LATENCY), .W(W)) u_coll (
    .clk(clk),
    .rst_n(rst_n),
    .clr_tag(accept || underrun),
    .clr_out(underrun || (ZEROIZE && accept)),
    .push(feed),
    .y_s0(sbox_y_s0),
    .y_s1(sbox_y_s1),
    .out_s0(state_out_s0),
    .out_s1(state_out_s1)
  );
endmodule
